uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, 4, number of requesters sharing one UART transmitter; fixed at 4 in this revision.
REQ-002 Parameter TIMEOUT_CYC, 200000, WAIT cycles allowed before tx_done is declared missing; range 2..2^20-1.
REQ-003 clk  input  1  system clock, all logic on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req  input  4  per-requester byte-request, level; held high while a byte is offered.
REQ-006 req_data  input  32  packed bytes, requester i at bits [8i+7:8i].
REQ-007 req_last  input  4  per-requester flag, offered byte is the last of its packet.
REQ-008 req_ack  output  4  one-cycle pulse to requester i; its byte was transmitted.
REQ-009 tx_dv  output  1  data-valid strobe to UART transmitter.
REQ-010 tx_data  output  8  byte to UART transmitter, stable from tx_dv until tx_done.
REQ-011 tx_done  input  1  transmitter finished-byte pulse.
REQ-012 busy  output  1  high whenever state is not IDLE.
REQ-013 grant_id  output  2  index of current or most recent grantee.
REQ-014 timeout_err  output  1  one-cycle pulse, transmission abandoned on timeout.

Function
REQ-015 FSM states IDLE, SEND, WAIT, GAP; all registered, no other reachable states; illegal encodings return to IDLE next edge.
REQ-016 IDLE: on edge with any req high, pick winner by round-robin starting at rr_ptr, wrapping 3->0; latch grant_id, tx_data=req_data[winner], last_q=req_last[winner]; go SEND.
REQ-017 No req high in IDLE: stay IDLE, outputs unchanged except strobes low.
REQ-018 SEND: tx_dv=1 for exactly this one cycle; clear timeout counter; go WAIT unconditionally.
REQ-019 tx_dv decodes state==SEND only; first tx_dv cycle begins one edge after the req-sampling edge.
REQ-020 tx_done while in SEND, IDLE or GAP is ignored.
REQ-021 WAIT: counter increments each cycle; on edge sampling tx_done=1, assert req_ack[grant_id] for the following cycle only and go GAP if last_q=0, else IDLE.
REQ-022 GAP (one cycle, lets requester present next byte): if req[grant_id]=1, latch req_data/req_last of grant_id and go SEND (packet lock, no re-arbitration); else go IDLE.
REQ-023 Packet end (last byte acked, req dropped in GAP, or timeout) sets rr_ptr=grant_id+1 mod 4.
REQ-024 WAIT: counter reaching TIMEOUT_CYC without tx_done -> timeout_err pulse one cycle, no req_ack, go IDLE, packet abandoned.
REQ-025 tx_done on the same edge the counter reaches TIMEOUT_CYC: done wins, no timeout_err.
REQ-026 At most one req_ack bit high in any cycle; req_ack and timeout_err never high together.
REQ-027 Requester dropping req while in SEND/WAIT does not abort the byte in flight; ack still issued.
REQ-028 Counter width 20 bits, saturating; no wrap.

Reset
REQ-029 rst high: state=IDLE, rr_ptr=0, grant_id=0, tx_data=0, tx_dv=0, req_ack=0, busy=0, timeout_err=0, counter=0, last_q=0, asynchronously.
REQ-030 rst mid-transmission abandons the packet with no ack; first arbitration after release favours requester 0.

Verification
REQ-031 req=0001, data0=0x55, last0=1; tx_done 10 cycles after tx_dv -> tx_dv one cycle, tx_data=0x55, req_ack=0001 one cycle, busy low after, rr_ptr=1.
REQ-032 req=1111 held, all last=1, data i=0x10+i -> transmit order 0x10,0x11,0x12,0x13,0x10, one ack per byte.
REQ-033 Requester 2 sends 3-byte packet 0xA1,0xA2,0xA3 (last on third) while req0 held high -> all three bytes before any requester-0 byte.
REQ-034 req=0010, tx_done never asserted, TIMEOUT_CYC=50 -> timeout_err pulse 50 cycles into WAIT, no ack, IDLE, next grant favours requester 2.
REQ-035 rst pulsed during WAIT of requester 3 -> all outputs 0 immediately; with req=1001 after release, requester 0 granted first.
REQ-036 tx_done forced in SEND and in GAP -> ignored, no extra ack, byte count unchanged.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among four requesters: round-robin between packets,
// packet lock within a packet, and a watchdog on the transmitter's tx_done pulse.
module uart_tx_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic [31:0] req_data,
    input  logic [3:0]  req_last,
    output logic [3:0]  req_ack,
    output logic        tx_dv,
    output logic [7:0]  tx_data,
    input  logic        tx_done,
    output logic        busy,
    output logic [1:0]  grant_id,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2,
        GAP  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  rr_q, rr_d;
    logic [1:0]  grant_q, grant_d;
    logic [7:0]  data_q, data_d;
    logic        last_q, last_d;
    logic [3:0]  ack_q, ack_d;
    logic        tout_q, tout_d;
    logic [19:0] cnt_q, cnt_d;
    logic [19:0] cnt_inc;
    logic        cnt_hit;
    logic [1:0]  winner;
    logic [1:0]  rr_idx;
    logic        found;

    // Round-robin search: first requesting index at or after rr_q, wrapping 3->0.
    always_comb begin
        found  = 1'b0;
        winner = rr_q;
        rr_idx = rr_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            rr_idx = rr_q + 2'(k);
            if (!found && req[rr_idx]) begin
                found  = 1'b1;
                winner = rr_idx;
            end
        end
    end

    // Watchdog counter saturates; the hit fires on the edge that would make it TIMEOUT_CYC.
    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 20'd1;
    assign cnt_hit = ({1'b0, cnt_q} + 21'd1) >= 21'(TIMEOUT_CYC);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (found) state_d = SEND;
            SEND: state_d = WAIT;
            WAIT: begin
                if (tx_done) begin
                    state_d = last_q ? IDLE : GAP;
                end else if (cnt_hit) begin
                    state_d = IDLE;
                end
            end
            GAP:     state_d = req[grant_q] ? SEND : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tx_dv = (state_q == SEND);
        busy  = (state_q != IDLE);
    end

    // Datapath: grant/byte latching, ack and timeout strobes, pointer advance at packet end.
    always_comb begin
        rr_d    = rr_q;
        grant_d = grant_q;
        data_d  = data_q;
        last_d  = last_q;
        ack_d   = 4'b0000;
        tout_d  = 1'b0;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = winner;
                    data_d  = req_data[{winner, 3'b000} +: 8];
                    last_d  = req_last[winner];
                end
            end
            SEND: cnt_d = '0;
            WAIT: begin
                cnt_d = cnt_inc;
                if (tx_done) begin
                    ack_d[grant_q] = 1'b1;
                    if (last_q) rr_d = grant_q + 2'd1;
                end else if (cnt_hit) begin
                    tout_d = 1'b1;
                    rr_d   = grant_q + 2'd1;
                end
            end
            GAP: begin
                if (req[grant_q]) begin
                    data_d = req_data[{grant_q, 3'b000} +: 8];
                    last_d = req_last[grant_q];
                end else begin
                    rr_d = grant_q + 2'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q    <= 2'd0;
            grant_q <= 2'd0;
            data_q  <= 8'd0;
            last_q  <= 1'b0;
            ack_q   <= 4'b0000;
            tout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            rr_q    <= rr_d;
            grant_q <= grant_d;
            data_q  <= data_d;
            last_q  <= last_d;
            ack_q   <= ack_d;
            tout_q  <= tout_d;
            cnt_q   <= cnt_d;
        end
    end

    assign req_ack     = ack_q;
    assign tx_data     = data_q;
    assign grant_id    = grant_q;
    assign timeout_err = tout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: per-requester byte queues, a UART
// responder with programmable tx_done delay, and a packet-level round-robin model.
module tb_uart_tx_arbiter;

    localparam int TOUT = 50;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = 4'b0000;
    logic [31:0] req_data = 32'd0;
    logic [3:0]  req_last = 4'b0000;
    logic        tx_done = 1'b0;
    logic [3:0]  req_ack;
    logic        tx_dv;
    logic [7:0]  tx_data;
    logic        busy;
    logic [1:0]  grant_id;
    logic        timeout_err;

    int tests_run = 0;
    int tests_failed = 0;

    // Requester traffic: q_len bytes per requester, q_last marks packet ends.
    logic [7:0] q_data [4][8];
    bit         q_last [4][8];
    int         q_len  [4];
    int         q_idx  [4];

    // Expected transmit stream from the packet-level model.
    logic [7:0] exp_byte [64];
    int         exp_id   [64];
    bit         exp_last [64];
    int         exp_n;
    int         model_rr = 0;

    uart_tx_arbiter #(
        .NUM_REQ     (4),
        .TIMEOUT_CYC (TOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ack     (req_ack),
        .tx_dv       (tx_dv),
        .tx_data     (tx_data),
        .tx_done     (tx_done),
        .busy        (busy),
        .grant_id    (grant_id),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic clear_queues();
        for (int j = 0; j < 4; j++) begin
            q_len[j] = 0;
            q_idx[j] = 0;
        end
    endtask

    task automatic add_byte(input int id, input logic [7:0] b, input bit last);
        q_data[id][q_len[id]] = b;
        q_last[id][q_len[id]] = last;
        q_len[id]++;
    endtask

    // Whole packets go out in round-robin order among requesters with bytes left.
    task automatic build_model();
        int  pidx [4];
        int  rr, w;
        bit  ended;
        rr    = model_rr;
        exp_n = 0;
        for (int j = 0; j < 4; j++) pidx[j] = 0;
        for (int p = 0; p < 32; p++) begin
            w = -1;
            for (int k = 0; k < 4; k++) begin
                if (w < 0 && pidx[(rr + k) % 4] < q_len[(rr + k) % 4]) w = (rr + k) % 4;
            end
            if (w >= 0) begin
                ended = 1'b0;
                while (!ended) begin
                    exp_byte[exp_n] = q_data[w][pidx[w]];
                    exp_id[exp_n]   = w;
                    exp_last[exp_n] = q_last[w][pidx[w]];
                    ended           = q_last[w][pidx[w]];
                    exp_n++;
                    pidx[w]++;
                end
                rr = (w + 1) % 4;
            end
        end
        model_rr = rr;
    endtask

    task automatic run_traffic(input int dmin, input int dmax, input bit spur_en, input string name);
        int         sent, acked, countdown, cur_id, bad_ack, bad_tout;
        bit         real_done, done_was, prev_dv, ack_seen;
        logic [3:0] exp_ack;
        build_model();
        @(negedge clk);
        for (int j = 0; j < 4; j++) begin
            q_idx[j] = 0;
            if (q_len[j] > 0) begin
                req[j]           = 1'b1;
                req_data[8*j +: 8] = q_data[j][0];
                req_last[j]      = q_last[j][0];
            end else begin
                req[j] = 1'b0;
            end
        end
        sent = 0; acked = 0; countdown = 0; cur_id = 0; bad_ack = 0; bad_tout = 0;
        real_done = 1'b0; prev_dv = 1'b0;
        for (int cyc = 0; cyc < 4000 && acked < exp_n; cyc++) begin
            @(negedge clk);
            done_was  = real_done;
            real_done = 1'b0;
            if (countdown > 0) begin
                countdown--;
                if (countdown == 0) begin
                    real_done = 1'b1;
                    tests_run++;
                    if (tx_data !== exp_byte[sent-1]) begin
                        tests_failed++;
                        $display("FAIL %s tx_data_stable: got %02h expected %02h", name, tx_data, exp_byte[sent-1]);
                    end
                end
            end
            if (tx_dv) begin
                tests_run++;
                if (prev_dv) begin
                    tests_failed++;
                    $display("FAIL %s tx_dv_width: tx_dv high on consecutive cycles, expected 1 cycle", name);
                end
                if (sent < exp_n) begin
                    tests_run++;
                    if (tx_data !== exp_byte[sent]) begin
                        tests_failed++;
                        $display("FAIL %s tx_data[%0d]: got %02h expected %02h", name, sent, tx_data, exp_byte[sent]);
                    end
                    tests_run++;
                    if (grant_id !== 2'(exp_id[sent])) begin
                        tests_failed++;
                        $display("FAIL %s grant_id[%0d]: got %0d expected %0d", name, sent, grant_id, exp_id[sent]);
                    end
                    $display("[TB] %s: byte %0d = %02h from requester %0d", name, sent, tx_data, grant_id);
                    cur_id = exp_id[sent];
                    sent++;
                end else begin
                    tests_run++;
                    tests_failed++;
                    $display("FAIL %s extra_tx: got byte %02h, expected no more bytes", name, tx_data);
                end
                countdown = $urandom_range(dmax, dmin);
            end
            ack_seen = (req_ack !== 4'b0000);
            if (done_was) begin
                exp_ack = 4'b0001 << cur_id;
                tests_run++;
                if (req_ack !== exp_ack) begin
                    tests_failed++;
                    $display("FAIL %s req_ack: got %b expected %b", name, req_ack, exp_ack);
                end
                tests_run++;
                if (busy !== (exp_last[sent-1] ? 1'b0 : 1'b1)) begin
                    tests_failed++;
                    $display("FAIL %s busy_after_ack: got %b expected %b", name, busy, !exp_last[sent-1]);
                end
                acked++;
                q_idx[cur_id]++;
                if (q_idx[cur_id] < q_len[cur_id]) begin
                    req_data[8*cur_id +: 8] = q_data[cur_id][q_idx[cur_id]];
                    req_last[cur_id]        = q_last[cur_id][q_idx[cur_id]];
                end else begin
                    req[cur_id] = 1'b0;
                end
            end else if (ack_seen) begin
                bad_ack++;
            end
            if (timeout_err) bad_tout++;
            tx_done = real_done | (spur_en & (tx_dv | ack_seen));
            prev_dv = tx_dv;
        end
        tests_run++;
        if (acked !== exp_n || sent !== exp_n) begin
            tests_failed++;
            $display("FAIL %s byte_count: sent %0d acked %0d expected %0d", name, sent, acked, exp_n);
        end
        tests_run++;
        if (bad_ack !== 0) begin
            tests_failed++;
            $display("FAIL %s unexpected_ack: got %0d stray acks expected 0", name, bad_ack);
        end
        tests_run++;
        if (bad_tout !== 0) begin
            tests_failed++;
            $display("FAIL %s unexpected_timeout: got %0d pulses expected 0", name, bad_tout);
        end
        @(negedge clk);
        tx_done = 1'b0;
        req     = 4'b0000;
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s busy_at_end: got %b expected 0", name, busy);
        end
    endtask

    task automatic check_all_zero(input string name);
        tests_run++;
        if ({tx_dv, busy, req_ack, timeout_err, grant_id, tx_data} !== 16'd0) begin
            tests_failed++;
            $display("FAIL %s outputs: dv=%b busy=%b ack=%b terr=%b gid=%0d data=%02h expected all 0",
                     name, tx_dv, busy, req_ack, timeout_err, grant_id, tx_data);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("reset_release");
        model_rr = 0;
    endtask

    task automatic test_single();
        clear_queues();
        add_byte(0, 8'h55, 1'b1);
        run_traffic(10, 10, 1'b0, "single");
    endtask

    task automatic test_rr_after_single();
        clear_queues();
        add_byte(0, 8'h20, 1'b1);
        add_byte(1, 8'h21, 1'b1);
        run_traffic(1, 3, 1'b0, "rr_after_single");
    endtask

    task automatic test_all_held();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_rr = 0;
        clear_queues();
        for (int j = 0; j < 4; j++) add_byte(j, 8'h10 + 8'(j), 1'b1);
        add_byte(0, 8'h10, 1'b1);
        run_traffic(2, 5, 1'b0, "all_held");
    endtask

    task automatic test_packet_lock();
        clear_queues();
        add_byte(0, 8'h30, 1'b1);
        add_byte(2, 8'hA1, 1'b0);
        add_byte(2, 8'hA2, 1'b0);
        add_byte(2, 8'hA3, 1'b1);
        run_traffic(1, 6, 1'b0, "packet_lock");
    endtask

    task automatic test_spurious_done();
        clear_queues();
        add_byte(1, 8'hC1, 1'b0);
        add_byte(1, 8'hC2, 1'b1);
        add_byte(3, 8'hD1, 1'b0);
        add_byte(3, 8'hD2, 1'b0);
        add_byte(3, 8'hD3, 1'b1);
        run_traffic(1, 4, 1'b1, "spurious_done");
    endtask

    task automatic test_done_at_limit();
        clear_queues();
        add_byte(0, 8'hE0, 1'b0);
        add_byte(0, 8'hE1, 1'b1);
        add_byte(3, 8'hE3, 1'b1);
        run_traffic(TOUT, TOUT, 1'b0, "done_at_limit");
    endtask

    task automatic test_timeout();
        int first, extra, acks;
        bit seen_dv;
        @(negedge clk);
        tx_done        = 1'b0;
        req            = 4'b0010;
        req_data[15:8] = 8'h66;
        req_last       = 4'b0010;
        seen_dv        = 1'b0;
        for (int c = 0; c < 20 && !seen_dv; c++) begin
            @(negedge clk);
            if (tx_dv) seen_dv = 1'b1;
        end
        tests_run++;
        if (seen_dv !== 1'b1 || tx_data !== 8'h66) begin
            tests_failed++;
            $display("FAIL timeout_send: dv_seen=%b data=%02h expected 1 and 66", seen_dv, tx_data);
        end
        first = -1; extra = 0; acks = 0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (req_ack !== 4'b0000) acks++;
            if (timeout_err) begin
                if (first < 0) begin
                    first = c;
                    $display("[TB] timeout: timeout_err seen %0d cycles after tx_dv", c);
                    tests_run++;
                    if (busy !== 1'b0) begin
                        tests_failed++;
                        $display("FAIL timeout_busy: got %b expected 0", busy);
                    end
                    req = 4'b0000;
                end else begin
                    extra++;
                end
            end
        end
        tests_run++;
        if (first !== TOUT + 1) begin
            tests_failed++;
            $display("FAIL timeout_time: got cycle %0d expected %0d", first, TOUT + 1);
        end
        tests_run++;
        if (acks !== 0 || extra !== 0) begin
            tests_failed++;
            $display("FAIL timeout_pulse: acks %0d extra pulses %0d expected 0 and 0", acks, extra);
        end
        req = 4'b0000;
        model_rr = 2;
    endtask

    task automatic test_after_timeout();
        clear_queues();
        add_byte(0, 8'h70, 1'b1);
        add_byte(1, 8'h71, 1'b1);
        add_byte(2, 8'h72, 1'b1);
        run_traffic(1, 5, 1'b0, "after_timeout");
    endtask

    task automatic test_reset_mid();
        bit seen_dv;
        @(negedge clk);
        req             = 4'b1000;
        req_data[31:24] = 8'h77;
        req_last        = 4'b1000;
        seen_dv         = 1'b0;
        for (int c = 0; c < 20 && !seen_dv; c++) begin
            @(negedge clk);
            if (tx_dv) seen_dv = 1'b1;
        end
        repeat (3) @(negedge clk);
        tests_run++;
        if (seen_dv !== 1'b1 || busy !== 1'b1 || grant_id !== 2'd3) begin
            tests_failed++;
            $display("FAIL reset_mid_wait: dv_seen=%b busy=%b gid=%0d expected 1 1 3", seen_dv, busy, grant_id);
        end
        #2 rst = 1'b1;
        #1 check_all_zero("reset_mid_async");
        @(negedge clk);
        check_all_zero("reset_mid_held");
        req = 4'b0000;
        rst = 1'b0;
        model_rr = 0;
        clear_queues();
        add_byte(0, 8'h40, 1'b1);
        add_byte(3, 8'h77, 1'b1);
        run_traffic(1, 4, 1'b0, "post_reset");
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            clear_queues();
            for (int j = 0; j < 4; j++) begin
                int n;
                n = $urandom_range(4, 0);
                for (int e = 0; e < n; e++) begin
                    add_byte(j, 8'($urandom), (e == n - 1) || ($urandom_range(2, 0) == 0));
                end
            end
            run_traffic(1, 8, r[0], "random");
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_rr_after_single();
        test_all_held();
        test_packet_lock();
        test_spurious_done();
        test_done_at_limit();
        test_timeout();
        test_after_timeout();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
